// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serializes host words LSB-first into ccff_head,
// with an optional read-back pass that compares ccff_tail against the resent stream.
module ccff_bitstream_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 1024,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  verify,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  IO_ISOL_N
);

  localparam int BL_WIDTH = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [BL_WIDTH-1:0]  FULL_BITS = BL_WIDTH'(WORD_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [WORD_WIDTH-1:0] r_buf, w_buf_nxt;
  logic [BL_WIDTH-1:0]   r_bits_left, w_bits_left_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_verify, w_verify_nxt;
  logic                  r_error, w_error_nxt;
  logic                  r_shift_en, r_busy, r_done, r_iso_n;
  logic                  w_active, w_active_nxt, w_shift, w_final, w_hs;

  assign w_active = (r_state == S_LOAD) || (r_state == S_VERIFY);
  // r_shift_en is registered from next-state values, so it always equals
  // "active state with bits left" for the current cycle.
  assign w_shift  = r_shift_en;
  assign w_final  = w_shift && (r_cnt == LAST_CNT);

  assign word_ready = w_active && !w_final &&
                      ((r_bits_left == '0) || ((r_bits_left == BL_WIDTH'(1)) && w_shift));
  assign w_hs       = word_ready && word_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_buf_nxt       = r_buf;
    w_bits_left_nxt = r_bits_left;
    w_cnt_nxt       = r_cnt;
    w_verify_nxt    = r_verify;
    w_error_nxt     = r_error;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt     = S_LOAD;
          w_buf_nxt       = '0;
          w_bits_left_nxt = '0;
          w_cnt_nxt       = '0;
          w_verify_nxt    = verify;
          w_error_nxt     = 1'b0;
        end
      end
      S_LOAD, S_VERIFY: begin
        if (w_shift) begin
          w_buf_nxt       = r_buf >> 1;
          w_bits_left_nxt = r_bits_left - BL_WIDTH'(1);
          w_cnt_nxt       = (r_cnt != FULL_CNT) ? r_cnt + CNT_WIDTH'(1) : r_cnt;
          if ((r_state == S_VERIFY) && (ccff_tail != r_buf[0])) begin
            w_error_nxt = 1'b1;
          end
        end
        if (w_hs) begin
          w_buf_nxt       = word_data;
          w_bits_left_nxt = FULL_BITS;
        end
        // Leftover bits of the last word never reach the chain.
        if (w_final) begin
          w_buf_nxt       = '0;
          w_bits_left_nxt = '0;
          if ((r_state == S_LOAD) && r_verify) begin
            w_state_nxt = S_VERIFY;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_active_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_VERIFY);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_bits_left <= '0;
      r_cnt       <= '0;
      r_verify    <= 1'b0;
      r_error     <= 1'b0;
      r_shift_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_iso_n     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf       <= w_buf_nxt;
      r_bits_left <= w_bits_left_nxt;
      r_cnt       <= w_cnt_nxt;
      r_verify    <= w_verify_nxt;
      r_error     <= w_error_nxt;
      r_shift_en  <= w_active_nxt && (w_bits_left_nxt != '0);
      r_busy      <= w_active_nxt;
      r_done      <= (w_state_nxt == S_DONE);
      r_iso_n     <= (w_state_nxt == S_DONE) && !w_error_nxt;
    end
  end

  assign ccff_head     = r_buf[0];
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign IO_ISOL_N     = r_iso_n;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: vector table, hand-written reset sequence and
// randomized loads, all checked against stream-level expectations and a chain model.
module tb_ccff_bitstream_loader;

  localparam int WW = 8;
  localparam int CL = 20;

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b1;
  logic          start = 1'b0;
  logic          verify = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic          busy, done, error, IO_ISOL_N;
  logic [CL-1:0] chain = '0;

  int n_checks = 0;
  int n_fail = 0;

  ccff_bitstream_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL)) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .verify       (verify),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .IO_ISOL_N    (IO_ISOL_N)
  );

  always #5 prog_clk = ~prog_clk;

  // External configuration chain: head enters flop 0, tail is the last flop.
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  typedef struct {
    string         name;
    logic          vfy;
    logic [WW-1:0] w0, w1, w2;
    logic [WW-1:0] v0, v1, v2;
    int            stall_word;
    int            stall_len;
    int            glitch_cyc;
    logic [CL-1:0] exp_p1;
    logic [CL-1:0] exp_p2;
    logic          exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CL-1:0] stream_of(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                              input logic [WW-1:0] c);
    logic [3*WW-1:0] all;
    all = {c, b, a};
    return all[CL-1:0];
  endfunction

  task automatic run_load(input vec_t v);
    logic [WW-1:0] q[$];
    logic [CL-1:0] last, exp_chain;
    int idx, pass, sh, hs_in_pass, busy_cyc, stall_left, cyc, npass;
    logic exp_err, err_next, withhold, prev_withheld, hs, shifted, exp_bit;
    q = {v.w0, v.w1, v.w2};
    if (v.vfy) begin
      q.push_back(v.v0);
      q.push_back(v.v1);
      q.push_back(v.v2);
    end
    npass = v.vfy ? 2 : 1;
    @(negedge prog_clk);
    start = 1'b1;
    verify = v.vfy;
    @(negedge prog_clk);
    start = 1'b0;
    verify = 1'b0;
    chk({v.name, ":start_busy"}, busy, 1);
    chk({v.name, ":start_done_clr"}, done, 0);
    chk({v.name, ":start_err_clr"}, error, 0);
    chk({v.name, ":start_isol"}, IO_ISOL_N, 0);
    chk({v.name, ":start_ready"}, word_ready, 1);
    idx = 0; pass = 0; sh = 0; hs_in_pass = 0; busy_cyc = 0; cyc = 0;
    stall_left = v.stall_len; exp_err = 1'b0; prev_withheld = 1'b0;
    while (busy && cyc < 500) begin
      busy_cyc++;
      err_next = 1'b0;
      shifted = 1'b0;
      if (hs_in_pass == 3) chk({v.name, ":ready_after_last"}, word_ready, 0);
      if (prev_withheld) chk({v.name, ":stall_no_shift"}, ccff_shift_en, 0);
      chk({v.name, ":error_track"}, error, exp_err);
      if (ccff_shift_en) begin
        exp_bit = (pass == 0) ? v.exp_p1[sh] : v.exp_p2[sh];
        chk({v.name, ":head_bit"}, ccff_head, exp_bit);
        if (pass == 1 && v.exp_p1[sh] != v.exp_p2[sh]) err_next = 1'b1;
        sh++;
        shifted = 1'b1;
      end
      withhold = 1'b0;
      if (idx < q.size() && idx == v.stall_word && stall_left > 0 && word_ready) begin
        withhold = 1'b1;
        stall_left--;
      end
      word_valid = (idx < q.size()) && !withhold;
      word_data  = (idx < q.size()) ? q[idx] : '0;
      hs = word_valid && word_ready;
      start  = (v.glitch_cyc > 0) && (cyc == v.glitch_cyc);
      verify = start;
      @(posedge prog_clk);
      if (hs) begin
        idx++;
        hs_in_pass++;
      end
      if (err_next) exp_err = 1'b1;
      if (shifted && sh == CL) begin
        pass++;
        sh = 0;
        hs_in_pass = 0;
      end
      prev_withheld = withhold;
      @(negedge prog_clk);
      cyc++;
    end
    word_valid = 1'b0;
    start = 1'b0;
    verify = 1'b0;
    if (cyc >= 500) chk({v.name, ":timeout"}, 1, 0);
    chk({v.name, ":busy_cycles"}, busy_cyc, npass * (1 + CL) + v.stall_len);
    chk({v.name, ":passes"}, pass, npass);
    chk({v.name, ":done"}, done, 1);
    chk({v.name, ":busy_end"}, busy, 0);
    chk({v.name, ":error"}, error, v.exp_err);
    chk({v.name, ":isol_n"}, IO_ISOL_N, !v.exp_err);
    chk({v.name, ":ready_done"}, word_ready, 0);
    chk({v.name, ":shift_en_done"}, ccff_shift_en, 0);
    last = v.vfy ? v.exp_p2 : v.exp_p1;
    for (int k = 0; k < CL; k++) exp_chain[CL-1-k] = last[k];
    chk({v.name, ":chain"}, chain, exp_chain);
  endtask

  initial begin
    logic [WW-1:0] rw[3];
    logic [3*WW-1:0] all2;
    vec_t r;
    int shifts, cyc, idx;
    logic hs;

    tbl[0] = '{"plain", 1'b0, 8'hA5, 8'h3C, 8'h0F, 8'hA5, 8'h3C, 8'h0F, 9, 0, 0,
               20'hF3CA5, 20'hF3CA5, 1'b0};
    tbl[1] = '{"verify_ok", 1'b1, 8'hA5, 8'h3C, 8'h0F, 8'hA5, 8'h3C, 8'h0F, 9, 0, 0,
               20'hF3CA5, 20'hF3CA5, 1'b0};
    tbl[2] = '{"verify_bad", 1'b1, 8'hA5, 8'h3C, 8'h0F, 8'h85, 8'h3C, 8'h0F, 9, 0, 0,
               20'hF3CA5, 20'hF3C85, 1'b1};
    tbl[3] = '{"stall", 1'b0, 8'hA5, 8'h3C, 8'h0F, 8'hA5, 8'h3C, 8'h0F, 1, 3, 0,
               20'hF3CA5, 20'hF3CA5, 1'b0};
    tbl[4] = '{"start_in_load", 1'b0, 8'hA5, 8'h3C, 8'h0F, 8'hA5, 8'h3C, 8'h0F, 9, 0, 7,
               20'hF3CA5, 20'hF3CA5, 1'b0};
    tbl[5] = '{"verify_discard", 1'b1, 8'hA5, 8'h3C, 8'h0F, 8'hA5, 8'h3C, 8'hFF, 9, 0, 0,
               20'hF3CA5, 20'hF3CA5, 1'b0};

    repeat (3) @(negedge prog_clk);
    chk("rst_ready", word_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_isol", IO_ISOL_N, 0);
    pReset = 1'b0;

    foreach (tbl[i]) run_load(tbl[i]);

    // Abort a load after 10 shifts with an asynchronous reset.
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    shifts = 0; cyc = 0; idx = 0;
    rw[0] = 8'hA5; rw[1] = 8'h3C; rw[2] = 8'h0F;
    while (shifts < 10 && cyc < 200) begin
      if (ccff_shift_en) shifts++;
      word_valid = idx < 3;
      word_data = (idx < 3) ? rw[idx] : '0;
      hs = word_valid && word_ready;
      @(posedge prog_clk);
      if (hs) idx++;
      @(negedge prog_clk);
      cyc++;
    end
    if (cyc >= 200) chk("rst_mid:timeout", 1, 0);
    chk("rst_mid:busy_before", busy, 1);
    #2 pReset = 1'b1;
    word_valid = 1'b0;
    #1;
    chk("rst_mid:ready", word_ready, 0);
    chk("rst_mid:head", ccff_head, 0);
    chk("rst_mid:shift_en", ccff_shift_en, 0);
    chk("rst_mid:busy", busy, 0);
    chk("rst_mid:done", done, 0);
    chk("rst_mid:error", error, 0);
    chk("rst_mid:isol", IO_ISOL_N, 0);
    @(negedge prog_clk);
    pReset = 1'b0;
    run_load(tbl[0]);

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 3; k++) rw[k] = WW'($urandom);
      r.name = "random";
      r.vfy = 1'($urandom_range(0, 1));
      r.w0 = rw[0]; r.w1 = rw[1]; r.w2 = rw[2];
      all2 = {rw[2], rw[1], rw[0]};
      if (r.vfy && $urandom_range(0, 1) == 1) all2[$urandom_range(0, 3*WW-1)] ^= 1'b1;
      r.v0 = all2[WW-1:0]; r.v1 = all2[2*WW-1:WW]; r.v2 = all2[3*WW-1:2*WW];
      r.stall_word = $urandom_range(0, 2);
      r.stall_len = $urandom_range(0, 4);
      r.glitch_cyc = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : 0;
      r.exp_p1 = stream_of(r.w0, r.w1, r.w2);
      r.exp_p2 = r.vfy ? stream_of(r.v0, r.v1, r.v2) : r.exp_p1;
      r.exp_err = r.vfy && (r.exp_p1 != r.exp_p2);
      run_load(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
